// File: rtl/pmu_seq_pkg.sv
// Shared types for the PMU power sequencer: state and fault codes,
// power-down step indices and the enable decode used by the output register.
package pmu_seq_pkg;

  typedef enum logic [3:0] {
    ST_OFF   = 4'd0,
    ST_BG    = 4'd1,
    ST_A85   = 4'd2,
    ST_D85   = 4'd3,
    ST_R25   = 4'd4,
    ST_DET   = 4'd5,
    ST_ON    = 4'd6,
    ST_DOWN  = 4'd7,
    ST_FAULT = 4'd8
  } pmu_state_e;

  typedef enum logic [2:0] {
    FLT_NONE = 3'd0,
    FLT_BG   = 3'd1,
    FLT_A85  = 3'd2,
    FLT_D85  = 3'd3,
    FLT_R25  = 3'd4,
    FLT_VD09 = 3'd5,
    FLT_VD25 = 3'd6,
    FLT_VD33 = 3'd7
  } pmu_fault_e;

  localparam logic [1:0] DN_STEP_RAIL = 2'd0;
  localparam logic [1:0] DN_STEP_D85  = 2'd1;
  localparam logic [1:0] DN_STEP_A85  = 2'd2;

  typedef struct packed {
    logic poc;
    logic vr85a;
    logic vr85d;
    logic vr25;
    logic ibias;
    logic vd09;
    logic vd25;
    logic vd33;
  } pmu_ena_t;

  // Enables accumulate along the power-up path and peel off in reverse during DOWN.
  function automatic pmu_ena_t ena_decode(pmu_state_e st, logic [1:0] step);
    pmu_ena_t e;
    e = '0;
    case (st)
      ST_BG:  e.poc = 1'b1;
      ST_A85: {e.poc, e.vr85a} = 2'b11;
      ST_D85: {e.poc, e.vr85a, e.vr85d} = 3'b111;
      ST_R25: {e.poc, e.vr85a, e.vr85d, e.vr25} = 4'b1111;
      ST_DET, ST_ON: e = '1;
      ST_DOWN: begin
        e.poc   = (step != DN_STEP_A85);
        e.vr85a = (step != DN_STEP_A85);
        e.vr85d = (step == DN_STEP_RAIL);
      end
      default: e = '0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/pmu_seq_sync2.sv
// Two-flop synchronizer for asynchronous analog flags, reset to 0.
module pmu_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pmu_seq.sv
// Power-up/power-down sequencer for the PMU analog macro.
//   state | meaning
//   OFF   | all enables low, waiting for pwr_up_req
//   BG    | POC on, waiting for bandgap ready
//   A85   | analog 0.85V regulator on, waiting for its ready
//   D85   | digital 0.85V regulator on, waiting for its ready
//   R25   | 2.5V regulator on, waiting for its ready
//   DET   | bias and detectors on, settling
//   ON    | powered, detectors supervised
//   DOWN  | three timed power-down steps
//   FAULT | everything off until fault_clr
module pmu_seq
  import pmu_seq_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 50000,
  parameter int SETTLE  = 1000,
  parameter int DEB     = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       pwr_up_req,
  input  logic       pwr_dn_req,
  input  logic       fault_clr,
  input  logic       a2d_bgrdy,
  input  logic       a2d_vr85ardy,
  input  logic       a2d_vr85drdy,
  input  logic       a2d_vr25rdy,
  input  logic       a2d_por,
  input  logic       a2d_vd09l,
  input  logic       a2d_vd25l,
  input  logic       a2d_vd33l,
  output logic       d2a_vr85aena,
  output logic       d2a_vr85dena,
  output logic       d2a_vr25ena,
  output logic       d2a_ibiasena,
  output logic       d2a_vd09ena,
  output logic       d2a_vd25ena,
  output logic       d2a_vd33ena,
  output logic       d2a_pocena,
  output logic [3:0] state,
  output logic       pwr_good,
  output logic       fault,
  output logic [2:0] fault_code
);

  localparam int DEB_W = $clog2(DEB + 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB - 1);

  logic [7:0] a2d_s;
  logic [3:0] rdy_s;
  logic       por_s;
  logic [2:0] vd_s;

  pmu_sync2 #(.W(8)) u_sync (
    .clk   (clk),
    .rst_n (resetn),
    .d_i   ({a2d_vd33l, a2d_vd25l, a2d_vd09l, a2d_por,
             a2d_vr25rdy, a2d_vr85drdy, a2d_vr85ardy, a2d_bgrdy}),
    .q_o   (a2d_s)
  );

  assign rdy_s = a2d_s[3:0];
  assign por_s = a2d_s[4];
  assign vd_s  = a2d_s[7:5];

  pmu_state_e              state_q, state_d;
  logic [1:0]              step_q, step_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [2:0][DEB_W-1:0]   deb_q, deb_d;
  pmu_fault_e              fault_code_q, fault_code_d;
  pmu_ena_t                ena_q;
  logic                    pwr_good_q;
  logic                    fault_q;

  logic       rdy_w;
  pmu_fault_e flt_w;
  pmu_state_e nxt_w;
  logic [2:0] trip;
  logic       timed;

  always_comb begin
    rdy_w = 1'b0;
    flt_w = FLT_NONE;
    nxt_w = ST_OFF;
    case (state_q)
      ST_BG:  begin rdy_w = rdy_s[0]; flt_w = FLT_BG;  nxt_w = ST_A85; end
      ST_A85: begin rdy_w = rdy_s[1]; flt_w = FLT_A85; nxt_w = ST_D85; end
      ST_D85: begin rdy_w = rdy_s[2]; flt_w = FLT_D85; nxt_w = ST_R25; end
      ST_R25: begin rdy_w = rdy_s[3]; flt_w = FLT_R25; nxt_w = ST_DET; end
      default: ;
    endcase
  end

  // A detector trips on its DEB-th consecutive low cycle; any high cycle restarts it.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      trip[i]  = 1'b0;
      deb_d[i] = '0;
      if (state_q == ST_ON && !vd_s[i]) begin
        trip[i]  = (deb_q[i] == DEB_LAST);
        deb_d[i] = trip[i] ? deb_q[i] : deb_q[i] + DEB_W'(1);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    fault_code_d = fault_code_q;
    if (por_s) begin
      state_d      = ST_OFF;
      step_d       = DN_STEP_RAIL;
      fault_code_d = FLT_NONE;
    end else begin
      case (state_q)
        ST_OFF: begin
          if (pwr_up_req && !pwr_dn_req) state_d = ST_BG;
        end
        ST_BG, ST_A85, ST_D85, ST_R25: begin
          if (!rdy_w && cnt_q == TO_LAST) begin
            state_d      = ST_FAULT;
            fault_code_d = flt_w;
          end else if (pwr_dn_req) begin
            state_d = ST_DOWN;
            step_d  = DN_STEP_RAIL;
          end else if (rdy_w) begin
            state_d = nxt_w;
          end
        end
        ST_DET: begin
          if (pwr_dn_req) begin
            state_d = ST_DOWN;
            step_d  = DN_STEP_RAIL;
          end else if (cnt_q == SET_LAST) begin
            state_d = ST_ON;
          end
        end
        ST_ON: begin
          if (|trip) begin
            state_d      = ST_FAULT;
            fault_code_d = trip[0] ? FLT_VD09 : (trip[1] ? FLT_VD25 : FLT_VD33);
          end else if (pwr_dn_req) begin
            state_d = ST_DOWN;
            step_d  = DN_STEP_RAIL;
          end
        end
        ST_DOWN: begin
          if (cnt_q == SET_LAST) begin
            if (step_q == DN_STEP_A85) begin
              state_d = ST_OFF;
              step_d  = DN_STEP_RAIL;
            end else begin
              step_d = step_q + 2'd1;
            end
          end
        end
        ST_FAULT: begin
          if (fault_clr && !pwr_up_req) begin
            state_d      = ST_OFF;
            fault_code_d = FLT_NONE;
          end
        end
        default: state_d = ST_OFF;
      endcase
    end

    timed = (state_q inside {ST_BG, ST_A85, ST_D85, ST_R25, ST_DET, ST_DOWN});
    if (state_d != state_q || step_d != step_q || !timed) cnt_d = '0;
    else                                                  cnt_d = cnt_q + CNT_W'(1);
  end

  // Outputs are registered from the next state so they change on state entry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_OFF;
      step_q       <= DN_STEP_RAIL;
      cnt_q        <= '0;
      deb_q        <= '0;
      fault_code_q <= FLT_NONE;
      ena_q        <= '0;
      pwr_good_q   <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      cnt_q        <= cnt_d;
      deb_q        <= deb_d;
      fault_code_q <= fault_code_d;
      ena_q        <= ena_decode(state_d, step_d);
      pwr_good_q   <= (state_d == ST_ON);
      fault_q      <= (state_d == ST_FAULT);
    end
  end

  assign d2a_pocena   = ena_q.poc;
  assign d2a_vr85aena = ena_q.vr85a;
  assign d2a_vr85dena = ena_q.vr85d;
  assign d2a_vr25ena  = ena_q.vr25;
  assign d2a_ibiasena = ena_q.ibias;
  assign d2a_vd09ena  = ena_q.vd09;
  assign d2a_vd25ena  = ena_q.vd25;
  assign d2a_vd33ena  = ena_q.vd33;
  assign state        = state_q;
  assign pwr_good     = pwr_good_q;
  assign fault        = fault_q;
  assign fault_code   = fault_code_q;

endmodule

// File: doc/pmu_seq.md
# pmu_seq

Digital power-up/power-down sequencer for the PMU analog macro. Runs in the always-on domain and drives the macro's regulator, bias and detector enables (D2A_*). It consumes the macro's ready, POR and voltage-detect flags (A2D_*), which are asynchronous to this block. It enables rails in a fixed order, supervises them with timeouts and debounced undervoltage checks, and reports `pwr_good`, the current state and a fault code to the system controller.

## Interface
Parameters:
- CNT_W, 16, width of the timeout/settle counter
- TIMEOUT, 50000, cycles allowed for each ready flag after its enable
- SETTLE, 1000, cycles for detector settle and each power-down step
- DEB, 4, consecutive low cycles before a detector fault is declared (≥1)

Ports:
- clk  in  1  always-on clock
- resetn  in  1  asynchronous, active-low reset
- pwr_up_req  in  1  level; request power-up
- pwr_dn_req  in  1  level; request power-down; wins over pwr_up_req
- fault_clr  in  1  pulse; clears FAULT
- a2d_bgrdy, a2d_vr85ardy, a2d_vr85drdy, a2d_vr25rdy, a2d_por  in  1 each  async macro flags
- a2d_vd09l, a2d_vd25l, a2d_vd33l  in  1 each  async low-threshold detectors; 1 = rail above threshold
- d2a_vr85aena, d2a_vr85dena, d2a_vr25ena  out  1 each  regulator enables
- d2a_ibiasena, d2a_vd09ena, d2a_vd25ena, d2a_vd33ena, d2a_pocena  out  1 each  bias/detector/POC enables
- state  out  4  current FSM state code
- pwr_good  out  1  high only in ON
- fault  out  1  high only in FAULT
- fault_code  out  3  cause of the last fault; held until cleared

## Operation
- All A2D inputs pass through 2-flop synchronizers. Every decision uses the synchronized value, so an input change is first visible 2 cycles later.
- States and codes:
  - OFF 0: all enables low.
  - BG 1: d2a_pocena high; wait for bgrdy.
  - A85 2: vr85aena high; wait for vr85ardy.
  - D85 3: vr85dena high; wait for vr85drdy.
  - R25 4: vr25ena high; wait for vr25rdy.
  - DET 5: ibiasena and vd09/25/33 enables high; wait SETTLE cycles.
  - ON 6.
  - DOWN 7.
  - FAULT 8.
- Enables are cumulative along the power-up path: every enable asserted by an earlier state stays high in later states.
- Power-up: in OFF, pwr_up_req=1 and pwr_dn_req=0 → BG. Each wait state advances on its ready flag. DET advances to ON after SETTLE cycles.
- Timeouts: the counter clears on every state entry. If the counter reaches TIMEOUT-1 without the awaited ready → FAULT with fault_code = BG 1, A85 2, D85 3, R25 4.
- ON supervision: each detector has its own DEB-cycle low counter. A detector low for DEB consecutive cycles → FAULT with code 5 (vd09), 6 (vd25) or 7 (vd33). If several trip in the same cycle, the lowest code wins. A single high cycle resets that detector's counter.
- pwr_dn_req=1 in any state BG..ON → DOWN. DOWN runs three steps, each SETTLE cycles long:
  - step 0: drop vr25ena, ibiasena and all vd enables.
  - step 1: drop vr85dena.
  - step 2: drop vr85aena and pocena, then go to OFF.
- FAULT: all enables low. Leave FAULT for OFF only when fault_clr=1 and pwr_up_req=0. fault_code clears on that exit.
- Synchronized a2d_por=1 sends any state to OFF with all enables low and clears fault_code. POR takes priority over every other event.

## Timing
- Reset values: state=OFF, all d2a_* =0, pwr_good=0, fault=0, fault_code=0, counters=0.
- All outputs are registered. Enables and status change in the first cycle of the new state.
- Latency from a ready input edge to the next enable: 3 cycles (2 synchronizer + 1 FSM).
- Priority within a cycle: POR > timeout/detector fault > pwr_dn_req > ready/advance.
- A ready flag and a timeout in the same cycle → advance; the flag wins.
- A ready flag dropping while its state is still waiting has no effect other than the continued wait. Ready loss after advancing is not monitored; only the detectors are supervised in ON.
- resetn assertion mid-sequence sets all outputs to reset values immediately, asynchronously.

## Structure
- `pmu_seq_pkg` holds:
  - `pmu_state_e`: a 4-bit enum with the codes above.
  - `pmu_fault_e`: a 3-bit enum with the codes above.
  - Localparam step indices for DOWN.
- Sub-module `pmu_sync2`: a parameterized-width 2-flop synchronizer with asynchronous active-low reset to 0. It is instantiated once, 8 bits wide.
- The state register, shared counter, DEB counters and the output decode are all in `pmu_seq`.

## Test plan
Bench parameters: TIMEOUT=100, SETTLE=10, DEB=4.
- Nominal power-up: models assert each ready 20 cycles after its enable → state runs 1,2,3,4,5,6; pwr_good=1; all 8 enables high.
- Power-down from ON: pulse pwr_dn_req → vr25ena, ibiasena and vd* drop after 1 cycle; vr85dena drops 10 cycles later; vr85aena and pocena drop 10 cycles after that; state returns to OFF (0).
- D85 timeout: vr85drdy held at 0 → FAULT after 100 cycles in D85; fault_code=3; all enables 0. fault_clr with pwr_up_req=0 → OFF, fault_code=0.
- Detector debounce: in ON, pull vd25l low for 3 cycles then release → no fault. Pull vd25l and vd09l low together for 4 cycles → fault_code=5.
- POR during R25, and resetn asserted during DET → both give OFF with all outputs at reset values. Also check: pwr_up_req and pwr_dn_req both held in OFF → state stays OFF.
